// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one sequential multiplier among N_REQ clients.
// Each operation runs clear -> run -> guard -> wait-for-ready -> respond, with a watchdog abort.
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 80
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   opa,
    input  logic [N_REQ*WIDTH-1:0]   opb,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [2*WIDTH-1:0]       result,
    output logic                     err,
    output logic                     busy,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    output logic                     mul_run,
    output logic                     mul_rst,
    input  logic                     mul_ready,
    input  logic [2*WIDTH-1:0]       mul_product
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        START,
        GUARD,
        WAIT,
        RESP
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       g_idx;
    logic [PTR_W-1:0]       pick;
    logic [PTR_W-1:0]       next_ptr;
    logic [WD_W-1:0]        wdog;
    logic [WD_W-1:0]        wdog_inc;
    logic                   clr_q;
    logic [WIDTH-1:0]       opa_arr [N_REQ];
    logic [WIDTH-1:0]       opb_arr [N_REQ];

    // First requester at or after ptr, searching cyclically.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!found && r[idx[PTR_W-1:0]]) begin
                sel   = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
        logic [N_REQ-1:0] o;
        o    = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign opa_arr[i] = opa[i*WIDTH +: WIDTH];
        assign opb_arr[i] = opb[i*WIDTH +: WIDTH];
    end

    always_comb begin
        pick     = rr_pick(req, ptr);
        next_ptr = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
        wdog_inc = wdog + 1'b1;
    end

    // The multiplier is also held in clear for as long as our own reset is asserted.
    assign mul_rst = rst | clr_q;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            g_idx            <= '0;
            wdog             <= '0;
            clr_q            <= 1'b0;
            gnt              <= '0;
            done             <= '0;
            result           <= '0;
            err              <= 1'b0;
            mul_run          <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            clr_q   <= 1'b0;
            mul_run <= 1'b0;
            done    <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        g_idx            <= pick;
                        gnt              <= onehot(pick);
                        mul_multiplicand <= opa_arr[pick];
                        mul_multiplier   <= opb_arr[pick];
                        clr_q            <= 1'b1;
                        state            <= CLR;
                    end
                end
                CLR: begin
                    mul_run <= 1'b1;
                    state   <= START;
                end
                START: begin
                    wdog  <= '0;
                    state <= GUARD;
                end
                // ready may still be high from the previous product; skip one sample.
                GUARD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_ready) begin
                        result <= mul_product;
                        err    <= 1'b0;
                        done   <= gnt;
                        state  <= RESP;
                    end else if (wdog_inc == WD_LIMIT) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= gnt;
                        state  <= RESP;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                RESP: begin
                    ptr   <= next_ptr;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
